// File: rtl/updown_pkg.sv
// Shared constants for the up/down counter block.
package updown_pkg;
    localparam int MODE_WRAP     = 0;
    localparam int MODE_SAT      = 1;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count and boundary-event computation for updown_counter.
module updown_next_calc
    import updown_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH:0]   MAX_W    = {1'b0, {WIDTH{1'b1}}},
    parameter logic [WIDTH:0]   STEP_W   = {{WIDTH{1'b0}}, 1'b1},
    parameter int               SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step_up,
    input  logic             step_down,
    output logic [WIDTH-1:0] next_count,
    output logic             up_event,
    output logic             down_event
);
    // MAX_W+1 always fits in WIDTH+1 bits, so wrap arithmetic stays exact.
    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] MOD_W = MAX_W + ONE_W;

    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   sum;
    logic             up_over;
    logic             down_under;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_down;
    logic [WIDTH-1:0] sub_down;

    always_comb begin
        count_x    = {1'b0, count};
        sum        = count_x + STEP_W;
        up_over    = (sum > MAX_W);
        down_under = (count_x < STEP_W);
        wrap_up    = WIDTH'(sum - MOD_W);
        wrap_down  = WIDTH'(count_x + MOD_W - STEP_W);
        sub_down   = WIDTH'(count_x - STEP_W);

        next_count = count;
        up_event   = 1'b0;
        down_event = 1'b0;

        if (load) begin
            next_count = ({1'b0, load_value} > MAX_W) ? MAX_W[WIDTH-1:0] : load_value;
        end else if (step_up) begin
            up_event = up_over;
            if (!up_over)
                next_count = sum[WIDTH-1:0];
            else if (SATURATE == MODE_SAT)
                next_count = MAX_W[WIDTH-1:0];
            else
                next_count = wrap_up;
        end else if (step_down) begin
            down_event = down_under;
            if (!down_under)
                next_count = sub_down;
            else if (SATURATE == MODE_SAT)
                next_count = '0;
            else
                next_count = wrap_down;
        end
    end
endmodule

// File: rtl/updown_counter.sv
// Parameterised up/down counter with wrap or saturate behaviour,
// boundary pulses and a sticky error flag.
module updown_counter
    import updown_pkg::*;
#(
    parameter int              WIDTH    = DEFAULT_WIDTH,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP     = 64'd1,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             increment,
    input  logic             decrement,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             overflow,
    output logic             underflow,
    output logic             sticky_err
);
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter: WIDTH must be in 2..32");
    end
    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("updown_counter: MAX_VAL must be in 1..2**WIDTH-1");
    end
    if (STEP < 64'd1 || STEP > MAX_VAL) begin : g_bad_step
        $error("updown_counter: STEP must be in 1..MAX_VAL");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $error("updown_counter: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH:0] MAX_W  = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH:0] STEP_W = STEP[WIDTH:0];

    logic             step_req;
    logic             step_up;
    logic             step_down;
    logic [WIDTH-1:0] next_count;
    logic             up_event;
    logic             down_event;

    // Load beats stepping; simultaneous inc+dec cancels to a hold.
    assign step_req  = enable && (increment ^ decrement) && !load;
    assign step_up   = step_req && increment;
    assign step_down = step_req && decrement;

    updown_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_W   (MAX_W),
        .STEP_W  (STEP_W),
        .SATURATE(SATURATE)
    ) u_next_calc (
        .count     (count),
        .load      (load),
        .load_value(load_value),
        .step_up   (step_up),
        .step_down (step_down),
        .next_count(next_count),
        .up_event  (up_event),
        .down_event(down_event)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            sticky_err <= 1'b0;
        end else begin
            count     <= next_count;
            overflow  <= up_event;
            underflow <= down_event;
            if (up_event || down_event)
                sticky_err <= 1'b1;
            else if (clear_flags)
                sticky_err <= 1'b0;
        end
    end

    assign at_max = ({1'b0, count} == MAX_W);
    assign at_min = (count == '0);
endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: four counter configurations driven by directed vectors.
module tb_updown_counter;
    logic       clk;
    logic       rst;
    logic [3:0] en, inc, dec, ld, clr;
    logic [7:0] lv [4];
    logic [3:0] c0, c1, c2;
    logic [7:0] c3;
    logic [3:0] amax, amin, ovf, unf, stk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         d;
        logic [7:0] cnt;
        logic       o;
        logic       u;
        logic       s;
        string      nm;
    } exp_t;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: wrap STEP=1, 1: wrap STEP=3, 2: saturate STEP=1 (all WIDTH=4, MAX=9); 3: defaults
    updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(0)) u_a (
        .clk(clk), .reset(rst), .enable(en[0]), .increment(inc[0]), .decrement(dec[0]),
        .load(ld[0]), .load_value(lv[0][3:0]), .clear_flags(clr[0]), .count(c0),
        .at_max(amax[0]), .at_min(amin[0]), .overflow(ovf[0]), .underflow(unf[0]),
        .sticky_err(stk[0]));
    updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(0)) u_b (
        .clk(clk), .reset(rst), .enable(en[1]), .increment(inc[1]), .decrement(dec[1]),
        .load(ld[1]), .load_value(lv[1][3:0]), .clear_flags(clr[1]), .count(c1),
        .at_max(amax[1]), .at_min(amin[1]), .overflow(ovf[1]), .underflow(unf[1]),
        .sticky_err(stk[1]));
    updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(1)) u_c (
        .clk(clk), .reset(rst), .enable(en[2]), .increment(inc[2]), .decrement(dec[2]),
        .load(ld[2]), .load_value(lv[2][3:0]), .clear_flags(clr[2]), .count(c2),
        .at_max(amax[2]), .at_min(amin[2]), .overflow(ovf[2]), .underflow(unf[2]),
        .sticky_err(stk[2]));
    updown_counter u_d (
        .clk(clk), .reset(rst), .enable(en[3]), .increment(inc[3]), .decrement(dec[3]),
        .load(ld[3]), .load_value(lv[3]), .clear_flags(clr[3]), .count(c3),
        .at_max(amax[3]), .at_min(amin[3]), .overflow(ovf[3]), .underflow(unf[3]),
        .sticky_err(stk[3]));

    function automatic logic [7:0] cnt_of(input int d);
        case (d)
            0:       return {4'b0, c0};
            1:       return {4'b0, c1};
            2:       return {4'b0, c2};
            default: return c3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    task automatic idle_inputs();
        en = '0; inc = '0; dec = '0; ld = '0; clr = '0;
    endtask

    // Drive one cycle of stimulus on counter d and queue the state expected after the edge.
    task automatic step(input int d, input int e, input int i, input int dn, input int l,
                        input int v, input int c, input int ecnt, input int eo,
                        input int eu, input int es, input string nm);
        exp_t x;
        @(negedge clk);
        en[d]  = (e != 0);
        inc[d] = (i != 0);
        dec[d] = (dn != 0);
        ld[d]  = (l != 0);
        clr[d] = (c != 0);
        lv[d]  = 8'(v);
        x.d = d; x.cnt = 8'(ecnt); x.o = (eo != 0); x.u = (eu != 0); x.s = (es != 0); x.nm = nm;
        sb.push_back(x);
        @(posedge clk);
        #2;
        idle_inputs();
    endtask

    task automatic rst_chk(input string tag);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s.u%0d.count", tag, d), cnt_of(d), 8'd0);
            chk($sformatf("%s.u%0d.overflow", tag, d), {7'b0, ovf[d]}, 8'd0);
            chk($sformatf("%s.u%0d.underflow", tag, d), {7'b0, unf[d]}, 8'd0);
            chk($sformatf("%s.u%0d.sticky", tag, d), {7'b0, stk[d]}, 8'd0);
            chk($sformatf("%s.u%0d.at_min", tag, d), {7'b0, amin[d]}, 8'd1);
            chk($sformatf("%s.u%0d.at_max", tag, d), {7'b0, amax[d]}, 8'd0);
        end
    endtask

    // Monitor: each edge presents a new registered state; compare it to the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                logic [7:0] mx;
                e  = sb.pop_front();
                mx = (e.d == 3) ? 8'd255 : 8'd9;
                chk({e.nm, ".count"}, cnt_of(e.d), e.cnt);
                chk({e.nm, ".overflow"}, {7'b0, ovf[e.d]}, {7'b0, e.o});
                chk({e.nm, ".underflow"}, {7'b0, unf[e.d]}, {7'b0, e.u});
                chk({e.nm, ".sticky"}, {7'b0, stk[e.d]}, {7'b0, e.s});
                chk({e.nm, ".at_max"}, {7'b0, amax[e.d]}, {7'b0, e.cnt == mx});
                chk({e.nm, ".at_min"}, {7'b0, amin[e.d]}, {7'b0, e.cnt == 8'd0});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t x;
        rst = 1'b1;
        idle_inputs();
        for (int d = 0; d < 4; d++) lv[d] = 8'd0;
        #1;
        rst_chk("por");
        @(negedge clk);
        rst = 1'b0;

        // u0: ten increments wrap 9 -> 0 with a single overflow
        for (int i = 1; i <= 10; i++)
            step(0, 1, 1, 0, 0, 0, 0, i % 10, (i == 10) ? 1 : 0, 0, (i == 10) ? 1 : 0,
                 $sformatf("a_inc%0d", i));
        step(0, 0, 0, 0, 1, 9,  0, 9, 0, 0, 1, "a_load9");
        step(0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 1, "a_ovf_with_clr");
        step(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, "a_clr");
        step(0, 1, 1, 0, 1, 15, 0, 9, 0, 0, 0, "a_load_clamp");
        step(0, 1, 1, 1, 0, 0,  0, 9, 0, 0, 0, "a_both_hold");
        step(0, 0, 1, 0, 0, 0,  0, 9, 0, 0, 0, "a_disabled");
        step(0, 1, 0, 1, 0, 0,  0, 8, 0, 0, 0, "a_dec");
        step(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, "a_load0");
        step(0, 1, 0, 1, 0, 0,  0, 9, 0, 1, 1, "a_unf_wrap");
        step(0, 0, 0, 0, 1, 6,  0, 6, 0, 0, 1, "a_load6");

        // u1: STEP=3 wrap
        step(1, 0, 0, 0, 1, 8, 0, 8, 0, 0, 0, "b_load8");
        step(1, 1, 0, 1, 0, 0, 0, 5, 0, 0, 0, "b_dec");
        step(1, 1, 1, 0, 0, 0, 0, 8, 0, 0, 0, "b_inc");
        step(1, 0, 0, 0, 1, 7, 0, 7, 0, 0, 0, "b_load7");
        step(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, "b_ovf_wrap");
        step(1, 1, 0, 1, 0, 0, 0, 7, 0, 1, 1, "b_unf_wrap");
        step(1, 0, 0, 0, 1, 6, 0, 6, 0, 0, 1, "b_load6");
        step(1, 1, 1, 0, 0, 0, 0, 9, 0, 0, 1, "b_inc_to_max");
        step(1, 0, 0, 0, 1, 3, 0, 3, 0, 0, 1, "b_load3");
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, "b_dec_to_zero");

        // u2: saturate
        for (int i = 1; i <= 3; i++)
            step(2, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, $sformatf("c_dec_sat%0d", i));
        step(2, 0, 0, 0, 1, 8, 0, 8, 0, 0, 1, "c_load8");
        step(2, 1, 1, 0, 0, 0, 0, 9, 0, 0, 1, "c_inc");
        step(2, 1, 1, 0, 0, 0, 0, 9, 1, 0, 1, "c_ovf_sat1");
        step(2, 1, 1, 0, 0, 0, 0, 9, 1, 0, 1, "c_ovf_sat2");
        step(2, 1, 0, 1, 0, 0, 0, 8, 0, 0, 1, "c_dec");
        step(2, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0, "c_clr");

        // u3: default parameters (8-bit, MAX=255)
        step(3, 0, 0, 0, 1, 255, 0, 255, 0, 0, 0, "d_load255");
        step(3, 1, 1, 0, 0, 0,   0, 0,   1, 0, 1, "d_ovf");
        step(3, 1, 0, 1, 0, 0,   0, 255, 0, 1, 1, "d_unf");
        step(3, 1, 0, 1, 0, 0,   0, 254, 0, 0, 1, "d_dec");

        // Reset pulsed between edges with an increment pending on u0 (count 6, sticky set)
        @(negedge clk);
        en[0]  = 1'b1;
        inc[0] = 1'b1;
        #1 rst = 1'b1;
        #1 rst_chk("mid_rst");
        #1 rst = 1'b0;
        x.d = 0; x.cnt = 8'd1; x.o = 1'b0; x.u = 1'b0; x.s = 1'b0; x.nm = "a_after_rst";
        sb.push_back(x);
        @(posedge clk);
        #2;
        idle_inputs();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the count width in bits (range 2..32).
REQ-002 The parameter MAX_VAL SHALL default to 2**WIDTH-1 and set the terminal count (range 1..2**WIDTH-1), giving count range 0..MAX_VAL.
REQ-003 The parameter STEP SHALL default to 1 and set the magnitude of each increment or decrement (range 1..MAX_VAL).
REQ-004 The parameter SATURATE SHALL default to 0, where 0 selects wrap mode and 1 selects saturate mode.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  qualifies increment and decrement.
REQ-008 increment  input  1  count-up request.
REQ-009 decrement  input  1  count-down request.
REQ-010 load  input  1  synchronous load of load_value.
REQ-011 load_value  input  WIDTH  value to load.
REQ-012 clear_flags  input  1  clears sticky_err.
REQ-013 count  output  WIDTH  registered count.
REQ-014 at_max  output  1  combinational; high when count==MAX_VAL.
REQ-015 at_min  output  1  combinational; high when count==0.
REQ-016 overflow  output  1  registered one-cycle pulse on an up-boundary event.
REQ-017 underflow  output  1  registered one-cycle pulse on a down-boundary event.
REQ-018 sticky_err  output  1  registered; latches any overflow or underflow.

Function
REQ-019 The block SHALL apply the following per-edge priority: load first, then (enable AND exactly one of increment/decrement), otherwise hold.
REQ-020 On load, count SHALL become min(load_value, MAX_VAL), with no overflow or underflow pulse, whatever the state of enable, increment and decrement.
REQ-021 When increment and decrement are both high, or enable is low, count SHALL hold and no pulse SHALL be generated.
REQ-022 An up-step SHALL compute count+STEP in WIDTH+1 bits; if the result is <=MAX_VAL, count SHALL take that result.
REQ-023 An up-step whose result exceeds MAX_VAL SHALL, in wrap mode, set count to count+STEP-(MAX_VAL+1), and in saturate mode set count to MAX_VAL; in both modes overflow SHALL pulse.
REQ-024 A down-step with count>=STEP SHALL set count to count-STEP.
REQ-025 A down-step with count<STEP SHALL, in wrap mode, set count to count+(MAX_VAL+1)-STEP, and in saturate mode set count to 0; in both modes underflow SHALL pulse.
REQ-026 In saturate mode, an up-step while already at MAX_VAL SHALL still pulse overflow, and a down-step while already at 0 SHALL still pulse underflow.
REQ-027 overflow and underflow SHALL be high for exactly the one cycle after the edge that produced the event, and SHALL never be high together.
REQ-028 Each edge on which overflow or underflow is set SHALL also set sticky_err.
REQ-029 clear_flags SHALL clear sticky_err on the next edge; if a set and a clear occur on the same edge, the set SHALL win.
REQ-030 Each count update SHALL take effect one cycle after the triggering edge, with no additional latency.

Reset
REQ-031 Asserting reset SHALL immediately force count=0, overflow=0, underflow=0 and sticky_err=0, so at_min=1 and at_max=0, independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard any pending step or load, and the first edge after reset deasserts SHALL evaluate inputs normally.

Structure
REQ-033 A shared package updown_pkg SHALL hold the constants MODE_WRAP=0 and MODE_SAT=1 and the default WIDTH.
REQ-034 A single combinational sub-module, updown_next_calc, SHALL compute the next count and the boundary-event flags; the top level SHALL contain only registers, priority logic and the at_max/at_min decode.
REQ-035 An elaboration-time check SHALL reject parameter values outside the ranges in REQ-001..REQ-004.

Verification
REQ-036 WIDTH=4, MAX_VAL=9, STEP=1, wrap; from 0, 10 increments -> count 1..9 then 0; overflow pulses exactly once, on the cycle count shows 0; sticky_err=1.
REQ-037 Same configuration, STEP=3, count=8, one decrement then one increment -> count 5, then count 8 with no pulse; load 7 then increment -> count 0 with overflow pulse.
REQ-038 WIDTH=4, MAX_VAL=9, STEP=1, saturate; count=0, three decrements -> count stays 0 and underflow pulses on each of the 3 cycles.
REQ-039 Load load_value=15 with MAX_VAL=9 while increment=1 and enable=1 -> count 9, no pulse; increment and decrement both high -> count holds.
REQ-040 clear_flags asserted on the same edge as an overflow -> sticky_err stays 1; clear_flags asserted alone on the next edge -> sticky_err becomes 0.
REQ-041 Reset pulsed between clock edges while count=6 and sticky_err=1 -> count 0 and all flags 0 immediately; the first increment after release -> count 1.
